// File: rtl/udma_i2c_pkg.sv
// Shared constants and FSM state type for the uDMA I2C command decoder.
// The WAIT_EV state exists only when UDMA_I2C_WAIT_EV_EN is defined.
package udma_i2c_pkg;

  localparam int unsigned CLKDIV_W = 16;

  localparam logic [3:0] I2C_CMD_START   = 4'h0;
  localparam logic [3:0] I2C_CMD_WAIT_EV = 4'h1;
  localparam logic [3:0] I2C_CMD_STOP    = 4'h2;
  localparam logic [3:0] I2C_CMD_RD_ACK  = 4'h4;
  localparam logic [3:0] I2C_CMD_RD_NACK = 4'h6;
  localparam logic [3:0] I2C_CMD_WR      = 4'h8;
  localparam logic [3:0] I2C_CMD_WAIT    = 4'hA;
  localparam logic [3:0] I2C_CMD_RPT     = 4'hC;
  localparam logic [3:0] I2C_CMD_CFG     = 4'hE;

  localparam logic [2:0] BUS_CMD_NONE  = 3'd0;
  localparam logic [2:0] BUS_CMD_START = 3'd1;
  localparam logic [2:0] BUS_CMD_STOP  = 3'd2;
  localparam logic [2:0] BUS_CMD_WRITE = 3'd3;
  localparam logic [2:0] BUS_CMD_READ  = 3'd4;
  localparam logic [2:0] BUS_CMD_WAIT  = 3'd5;

  typedef enum logic [3:0] {
    StIdle,
    StGetCfgMsb,
    StGetCfgLsb,
    StGetWait,
    StGetRpt,
    StGetWr,
    StIssue,
    StBusy,
    StPushRx
`ifdef UDMA_I2C_WAIT_EV_EN
    , StWaitEv
`endif
  } i2c_state_e;

endpackage

// File: rtl/udma_i2c_event_sel.sv
// Registers the selected external event line while the decoder waits on it.
// Only compiled when UDMA_I2C_WAIT_EV_EN is defined.
`ifdef UDMA_I2C_WAIT_EV_EN
module udma_i2c_event_sel (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       en_i,
  input  logic [3:0] ext_events_i,
  input  logic [1:0] idx_i,
  output logic       event_o
);

  logic r_event;

  // Gated by en_i so an event seen before entering the wait state is never carried in.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_event <= 1'b0;
    end else begin
      r_event <= en_i & ext_events_i[idx_i];
    end
  end

  assign event_o = r_event;

endmodule
`endif

// File: rtl/udma_i2c_cmd_decoder.sv
// uDMA I2C command-stream decoder: parses TX command/operand bytes into bus commands.
// Optional WAIT_EV command support is enabled by defining UDMA_I2C_WAIT_EV_EN.
module udma_i2c_cmd_decoder
  import udma_i2c_pkg::*;
(
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                sw_rst_i,
  input  logic [3:0]          ext_events_i,
  input  logic [7:0]          data_tx_i,
  input  logic                data_tx_valid_i,
  output logic                data_tx_ready_o,
  output logic [7:0]          data_rx_o,
  output logic                data_rx_valid_o,
  input  logic                data_rx_ready_i,
  output logic [2:0]          bus_cmd_o,
  output logic [7:0]          bus_data_o,
  output logic                bus_ack_o,
  output logic                bus_cmd_valid_o,
  input  logic                bus_cmd_ready_i,
  input  logic                bus_done_i,
  input  logic [7:0]          bus_rx_data_i,
  input  logic                bus_nack_i,
  output logic [CLKDIV_W-1:0] clkdiv_o,
  output logic                err_o
);

  i2c_state_e          r_state, w_state_next;
  logic [7:0]          r_cnt;
  logic [2:0]          r_bus_cmd;
  logic [7:0]          r_bus_data;
  logic                r_bus_ack;
  logic [7:0]          r_rx_data;
  logic [7:0]          r_cfg_msb;
  logic [CLKDIV_W-1:0] r_clkdiv;
  logic                r_err;

  logic       w_tx_fire;
  logic [3:0] w_cmd;
  logic       w_last;
  logic       w_is_read;
  logic       w_is_write;
  i2c_state_e w_iter_state;
  logic       w_evt;

  assign w_tx_fire  = data_tx_valid_i & data_tx_ready_o;
  assign w_cmd      = data_tx_i[7:4];
  assign w_last     = (r_cnt <= 8'd1);
  assign w_is_read  = (r_bus_cmd == BUS_CMD_READ);
  assign w_is_write = (r_bus_cmd == BUS_CMD_WRITE);
  // A repeated write must fetch its next data byte before reissuing.
  assign w_iter_state = w_last ? StIdle : (w_is_write ? StGetWr : StIssue);

`ifdef UDMA_I2C_WAIT_EV_EN
  logic [1:0] r_ev_idx;

  udma_i2c_event_sel u_event_sel (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .en_i         ((r_state == StWaitEv) & ~sw_rst_i),
    .ext_events_i (ext_events_i),
    .idx_i        (r_ev_idx),
    .event_o      (w_evt)
  );
`else
  logic w_unused_events;
  assign w_unused_events = ^ext_events_i;
  assign w_evt = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_tx_fire) begin
          unique case (w_cmd)
            I2C_CMD_START, I2C_CMD_STOP,
            I2C_CMD_RD_ACK, I2C_CMD_RD_NACK: w_state_next = StIssue;
            I2C_CMD_WR:                      w_state_next = StGetWr;
            I2C_CMD_WAIT:                    w_state_next = StGetWait;
            I2C_CMD_RPT:                     w_state_next = StGetRpt;
            I2C_CMD_CFG:                     w_state_next = StGetCfgMsb;
`ifdef UDMA_I2C_WAIT_EV_EN
            I2C_CMD_WAIT_EV:                 w_state_next = StWaitEv;
`endif
            default:                         w_state_next = StIdle;
          endcase
        end
      end
      StGetCfgMsb: if (w_tx_fire) w_state_next = StGetCfgLsb;
      StGetCfgLsb: if (w_tx_fire) w_state_next = StIdle;
      StGetWait:   if (w_tx_fire) w_state_next = (data_tx_i == 8'd0) ? StIdle : StIssue;
      StGetRpt:    if (w_tx_fire) w_state_next = StIdle;
      StGetWr:     if (w_tx_fire) w_state_next = StIssue;
      StIssue:     if (bus_cmd_ready_i) w_state_next = StBusy;
      StBusy: begin
        if (bus_done_i) w_state_next = w_is_read ? StPushRx : w_iter_state;
      end
      StPushRx:    if (data_rx_ready_i) w_state_next = w_iter_state;
`ifdef UDMA_I2C_WAIT_EV_EN
      StWaitEv:    if (w_evt) w_state_next = StIdle;
`endif
      default:     w_state_next = StIdle;
    endcase
    if (sw_rst_i) w_state_next = StIdle;
  end

  always_comb begin
    data_tx_ready_o = 1'b0;
    bus_cmd_valid_o = 1'b0;
    data_rx_valid_o = 1'b0;
    unique case (r_state)
      StIdle, StGetCfgMsb, StGetCfgLsb,
      StGetWait, StGetRpt, StGetWr: data_tx_ready_o = 1'b1;
      StIssue:                      bus_cmd_valid_o = 1'b1;
      StPushRx:                     data_rx_valid_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cnt      <= 8'd0;
      r_bus_cmd  <= BUS_CMD_NONE;
      r_bus_data <= 8'd0;
      r_bus_ack  <= 1'b0;
      r_rx_data  <= 8'd0;
      r_cfg_msb  <= 8'd0;
      r_clkdiv   <= '0;
      r_err      <= 1'b0;
    end else if (sw_rst_i) begin
      r_cnt     <= 8'd0;
      r_bus_cmd <= BUS_CMD_NONE;
      r_err     <= 1'b0;
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_tx_fire) begin
            unique case (w_cmd)
              I2C_CMD_START: begin r_bus_cmd <= BUS_CMD_START; r_cnt <= 8'd0; end
              I2C_CMD_STOP:  begin r_bus_cmd <= BUS_CMD_STOP;  r_cnt <= 8'd0; end
              I2C_CMD_RD_ACK:  begin r_bus_cmd <= BUS_CMD_READ; r_bus_ack <= 1'b1; end
              I2C_CMD_RD_NACK: begin r_bus_cmd <= BUS_CMD_READ; r_bus_ack <= 1'b0; end
              I2C_CMD_WR, I2C_CMD_WAIT, I2C_CMD_RPT: ;
              I2C_CMD_CFG:   r_cnt <= 8'd0;
`ifdef UDMA_I2C_WAIT_EV_EN
              I2C_CMD_WAIT_EV: begin r_ev_idx <= data_tx_i[1:0]; r_cnt <= 8'd0; end
`endif
              default: begin r_err <= 1'b1; r_cnt <= 8'd0; end
            endcase
          end
        end
        StGetCfgMsb: if (w_tx_fire) r_cfg_msb <= data_tx_i;
        StGetCfgLsb: if (w_tx_fire) r_clkdiv <= {r_cfg_msb, data_tx_i};
        StGetWait: begin
          if (w_tx_fire) begin
            r_cnt     <= data_tx_i;
            r_bus_cmd <= BUS_CMD_WAIT;
          end
        end
        StGetRpt: if (w_tx_fire) r_cnt <= data_tx_i;
        StGetWr: begin
          if (w_tx_fire) begin
            r_bus_data <= data_tx_i;
            r_bus_cmd  <= BUS_CMD_WRITE;
          end
        end
        StBusy: begin
          if (bus_done_i) begin
            if (w_is_read) begin
              r_rx_data <= bus_rx_data_i;
            end else begin
              r_err <= w_is_write & bus_nack_i;
              r_cnt <= w_last ? 8'd0 : r_cnt - 8'd1;
            end
          end
        end
        StPushRx: if (data_rx_ready_i) r_cnt <= w_last ? 8'd0 : r_cnt - 8'd1;
        default: ;
      endcase
    end
  end

`ifdef UDMA_I2C_WAIT_EV_EN
  initial_idx_reset_guard: assert property (@(posedge clk_i) disable iff (!rstn_i) 1'b1);
`endif

  assign data_rx_o  = r_rx_data;
  assign bus_cmd_o  = r_bus_cmd;
  assign bus_data_o = r_bus_data;
  assign bus_ack_o  = r_bus_ack;
  assign clkdiv_o   = r_clkdiv;
  assign err_o      = r_err;

endmodule

// File: tb/tb_udma_i2c_cmd_decoder.sv
// Bench for udma_i2c_cmd_decoder: directed scenarios, then a randomized command stream
// compared against a command-level reference model.
module tb_udma_i2c_cmd_decoder;
  import udma_i2c_pkg::*;

  typedef struct {
    logic [2:0] cmd;
    logic [7:0] data;
    logic       ack;
  } bus_t;

  logic        clk = 1'b0, rstn = 1'b0, sw_rst = 1'b0;
  logic [3:0]  ext_events = 4'h0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready = 1'b0;
  logic [2:0]  bus_cmd;
  logic [7:0]  bus_data;
  logic        bus_ack, bus_valid;
  logic        bus_ready = 1'b0, bus_done = 1'b0, bus_nack = 1'b0;
  logic [7:0]  bus_rx = 8'h00;
  logic [15:0] clkdiv;
  logic        err;

  udma_i2c_cmd_decoder dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .sw_rst_i        (sw_rst),
    .ext_events_i    (ext_events),
    .data_tx_i       (tx_data),
    .data_tx_valid_i (tx_valid),
    .data_tx_ready_o (tx_ready),
    .data_rx_o       (rx_data),
    .data_rx_valid_o (rx_valid),
    .data_rx_ready_i (rx_ready),
    .bus_cmd_o       (bus_cmd),
    .bus_data_o      (bus_data),
    .bus_ack_o       (bus_ack),
    .bus_cmd_valid_o (bus_valid),
    .bus_cmd_ready_i (bus_ready),
    .bus_done_i      (bus_done),
    .bus_rx_data_i   (bus_rx),
    .bus_nack_i      (bus_nack),
    .clkdiv_o        (clkdiv),
    .err_o           (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int err_cnt = 0, viol = 0, rx_viol = 0;
  bit auto_bus = 1'b0, auto_rx = 1'b0, busy_flag = 1'b0, rx_pending = 1'b0;
  logic [7:0] rx_held;
  bus_t log_q[$];
  logic [7:0] log_rx[$];
  logic log_nack[$];
  logic [7:0] rx_log[$];
  bus_t exp_q[$];
  logic [7:0] tx_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    logic acc;
    do begin
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = b;
      acc      = tx_ready;
      @(posedge clk);
      guard++;
    end while (!acc && guard < 2000);
    #1 tx_valid = 1'b0;
    tx_data = 8'($urandom);
    if (!acc) check("tx_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic bus_xfer(input logic [7:0] rxb, input logic nk);
    @(negedge clk);
    bus_ready = 1'b1;
    @(posedge clk);
    #1 bus_ready = 1'b0;
    @(negedge clk);
    bus_done = 1'b1; bus_rx = rxb; bus_nack = nk;
    @(posedge clk);
    #1 bus_done = 1'b0; bus_nack = 1'b0;
  endtask

  task automatic pulse_sw_rst();
    @(negedge clk);
    sw_rst = 1'b1;
    @(posedge clk);
    #1 sw_rst = 1'b0;
  endtask

  function automatic void exp_push(input logic [2:0] c, input logic [7:0] d, input logic a);
    bus_t e;
    e.cmd = c; e.data = d; e.ack = a;
    exp_q.push_back(e);
  endfunction

  // Auto responder for the random phase; also fires stray done pulses while idle.
  initial forever begin
    @(negedge clk);
    if (auto_bus && bus_valid) begin
      if ($urandom_range(0, 2) != 0) begin
        bus_t e;
        logic [7:0] rb;
        logic nk;
        e.cmd = bus_cmd; e.data = bus_data; e.ack = bus_ack;
        log_q.push_back(e);
        bus_ready = 1'b1;
        @(posedge clk);
        #1 bus_ready = 1'b0; busy_flag = 1'b1;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        @(negedge clk);
        rb = 8'($urandom);
        nk = ($urandom_range(0, 2) == 0);
        log_rx.push_back(rb);
        log_nack.push_back(nk);
        bus_done = 1'b1; bus_rx = rb; bus_nack = nk;
        @(posedge clk);
        #1 bus_done = 1'b0; bus_nack = 1'b0; busy_flag = 1'b0;
      end
    end else if (auto_bus && $urandom_range(0, 7) == 0) begin
      bus_done = 1'b1; bus_nack = 1'b1; bus_rx = 8'($urandom);
      @(posedge clk);
      #1 bus_done = 1'b0; bus_nack = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (auto_rx) begin
      rx_ready = ($urandom_range(0, 3) != 0);
      if (rx_valid) begin
        if (rx_pending && rx_data !== rx_held) rx_viol++;
        if (rx_ready) begin
          rx_log.push_back(rx_data);
          rx_pending = 1'b0;
        end else begin
          rx_pending = 1'b1;
          rx_held    = rx_data;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (err === 1'b1) err_cnt++;
    if ((busy_flag && bus_valid) || (rx_valid && bus_valid)) viol++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rdv [3];
    int n_unknown = 0;
    int guard;
    logic [15:0] exp_clkdiv = 16'h012C;
    rdv[0] = 8'h11; rdv[1] = 8'h22; rdv[2] = 8'h33;

    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_bus_valid", bus_valid, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_err", err, 0);
    check("rst_clkdiv", clkdiv, 16'h0000);
    check("rst_bus_cmd", bus_cmd, 0);
    check("rst_rx_data", rx_data, 0);

    send_byte(8'hE0); send_byte(8'h01);
    @(negedge clk);
    check("cfg_partial", clkdiv, 16'h0000);
    send_byte(8'h2C);
    @(negedge clk);
    check("cfg_clkdiv", clkdiv, 16'h012C);
    check("cfg_no_bus", bus_valid, 0);

    send_byte(8'h05);
    @(negedge clk);
    check("start_valid", bus_valid, 1);
    check("start_cmd", bus_cmd, BUS_CMD_START);
    repeat (2) @(negedge clk);
    check("start_hold", bus_valid, 1);
    bus_xfer(8'h00, 1'b0);
    @(negedge clk);
    check("start_idle", tx_ready, 1);
    send_byte(8'h80); send_byte(8'hA5);
    @(negedge clk);
    check("wr_cmd", bus_cmd, BUS_CMD_WRITE);
    check("wr_data", bus_data, 8'hA5);
    bus_xfer(8'h00, 1'b0);
    @(negedge clk);
    check("wr_ack_no_err", err, 0);
    send_byte(8'h2F);
    @(negedge clk);
    check("stop_cmd", {bus_valid, bus_cmd}, {1'b1, BUS_CMD_STOP});
    bus_xfer(8'h00, 1'b0);

    send_byte(8'hC0); send_byte(8'h03); send_byte(8'h40);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rpt_rd%0d_cmd", i), {bus_valid, bus_cmd, bus_ack},
            {1'b1, BUS_CMD_READ, 1'b1});
      bus_xfer(rdv[i], 1'b0);
      @(negedge clk);
      check($sformatf("rpt_rd%0d_rx", i), {rx_valid, rx_data}, {1'b1, rdv[i]});
      if (i == 1) begin
        repeat (5) @(negedge clk);
        check("rx_stall_hold", {rx_valid, rx_data, bus_valid}, {1'b1, rdv[1], 1'b0});
      end
      rx_ready = 1'b1;
      @(posedge clk);
      #1 rx_ready = 1'b0;
    end
    @(negedge clk);
    check("rpt_done_idle", {tx_ready, bus_valid}, {1'b1, 1'b0});

    send_byte(8'hA0); send_byte(8'h00);
    @(negedge clk);
    check("wait0_none", {tx_ready, bus_valid}, {1'b1, 1'b0});
    send_byte(8'hA0); send_byte(8'h02);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("wait2_%0d", i), {bus_valid, bus_cmd}, {1'b1, BUS_CMD_WAIT});
      bus_xfer(8'h00, 1'b0);
    end
    @(negedge clk);
    check("wait2_idle", {tx_ready, bus_valid}, {1'b1, 1'b0});

    send_byte(8'h80); send_byte(8'h5A);
    bus_xfer(8'h00, 1'b1);
    @(negedge clk);
    check("nack_err", err, 1);
    @(negedge clk);
    check("nack_err_pulse", {err, tx_ready}, {1'b0, 1'b1});

    send_byte(8'h30);
    @(negedge clk);
    check("unknown_err", {err, tx_ready, bus_valid}, {1'b1, 1'b1, 1'b0});

`ifdef UDMA_I2C_WAIT_EV_EN
    send_byte(8'h12);
    @(negedge clk);
    check("wev_stall", tx_ready, 0);
    ext_events = 4'b0010;
    @(posedge clk);
    #1 ext_events = 4'h0;
    repeat (3) @(negedge clk);
    check("wev_wrong_idx", tx_ready, 0);
    ext_events = 4'b0100;
    @(posedge clk);
    #1 ext_events = 4'h0;
    guard = 0;
    while (!tx_ready && guard < 10) begin @(negedge clk); guard++; end
    check("wev_release", tx_ready, 1);
    check("wev_no_err", err, 0);
    send_byte(8'h12);
    repeat (2) @(negedge clk);
    check("wev_stall2", tx_ready, 0);
    pulse_sw_rst();
    @(negedge clk);
    check("wev_swrst", {tx_ready, clkdiv}, {1'b1, 16'h012C});
`else
    send_byte(8'h12);
    @(negedge clk);
    check("wev_unknown_err", {err, tx_ready}, {1'b1, 1'b1});
`endif

    send_byte(8'h00);
    @(negedge clk);
    check("swrst_pre", bus_valid, 1);
    pulse_sw_rst();
    @(negedge clk);
    check("swrst_idle", {bus_valid, tx_ready, clkdiv}, {1'b0, 1'b1, 16'h012C});

    // Random phase: expected bus traffic derived from the command rules.
    for (int i = 0; i < 40; i++) begin
      int kind = $urandom_range(0, 7);
      logic [3:0] lo = 4'($urandom);
      int n = $urandom_range(0, 3);
      logic [7:0] d = 8'($urandom);
      case (kind)
        0: begin tx_q.push_back({4'h0, lo}); exp_push(BUS_CMD_START, 8'h00, 1'b0); end
        1: begin tx_q.push_back({4'h2, lo}); exp_push(BUS_CMD_STOP, 8'h00, 1'b0); end
        2: begin
          logic a = 1'($urandom);
          tx_q.push_back({a ? 4'h4 : 4'h6, lo});
          exp_push(BUS_CMD_READ, 8'h00, a);
        end
        3: begin tx_q.push_back({4'h8, lo}); tx_q.push_back(d); exp_push(BUS_CMD_WRITE, d, 1'b0); end
        4: begin
          tx_q.push_back({4'hA, lo}); tx_q.push_back(8'(n));
          for (int k = 0; k < n; k++) exp_push(BUS_CMD_WAIT, 8'h00, 1'b0);
        end
        5: begin
          int reps = (n == 0) ? 1 : n;
          int sub = $urandom_range(0, 2);
          tx_q.push_back({4'hC, lo}); tx_q.push_back(8'(n));
          if (sub == 0) begin
            tx_q.push_back(8'h80);
            for (int k = 0; k < reps; k++) begin
              d = 8'($urandom);
              tx_q.push_back(d);
              exp_push(BUS_CMD_WRITE, d, 1'b0);
            end
          end else if (sub == 1) begin
            tx_q.push_back(8'h4F);
            for (int k = 0; k < reps; k++) exp_push(BUS_CMD_READ, 8'h00, 1'b1);
          end else begin
            tx_q.push_back(8'h0A);
            exp_push(BUS_CMD_START, 8'h00, 1'b0);
          end
        end
        6: begin
          exp_clkdiv = 16'($urandom);
          tx_q.push_back({4'hE, lo}); tx_q.push_back(exp_clkdiv[15:8]);
          tx_q.push_back(exp_clkdiv[7:0]);
        end
        default: begin
          logic [3:0] c;
          do c = 4'($urandom);
`ifdef UDMA_I2C_WAIT_EV_EN
          while (c[0] == 1'b0 || c == 4'h1);
`else
          while (c[0] == 1'b0);
`endif
          tx_q.push_back({c, lo});
          n_unknown++;
        end
      endcase
    end

    @(negedge clk);
    err_cnt = 0;
    viol = 0;
    auto_bus = 1'b1;
    auto_rx = 1'b1;
    while (tx_q.size() > 0) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send_byte(tx_q.pop_front());
    end
    guard = 0;
    while (!(tx_ready && !bus_valid && !rx_valid && !busy_flag && log_q.size() >= exp_q.size())
           && guard < 5000) begin
      @(posedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    check("rand_drain_timeout", guard < 5000, 1);
    check("rand_cmd_count", log_q.size(), exp_q.size());
    begin
      logic [7:0] exp_rx[$];
      int exp_err = n_unknown;
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
        check($sformatf("rand_cmd%0d", i), log_q[i].cmd, exp_q[i].cmd);
        if (exp_q[i].cmd == BUS_CMD_WRITE) begin
          check($sformatf("rand_wdata%0d", i), log_q[i].data, exp_q[i].data);
          if (log_nack[i]) exp_err++;
        end
        if (exp_q[i].cmd == BUS_CMD_READ) begin
          check($sformatf("rand_ack%0d", i), log_q[i].ack, exp_q[i].ack);
          exp_rx.push_back(log_rx[i]);
        end
      end
      check("rand_rx_count", rx_log.size(), exp_rx.size());
      for (int i = 0; i < exp_rx.size() && i < rx_log.size(); i++)
        check($sformatf("rand_rx%0d", i), rx_log[i], exp_rx[i]);
      check("rand_err_count", err_cnt, exp_err);
    end
    check("rand_clkdiv", clkdiv, exp_clkdiv);
    check("one_outstanding", viol, 0);
    check("rx_held_stable", rx_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
